// File: rtl/tis_pkg.sv
// Shared types and encodings for the TIS-100-style node sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package tis_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_SWP = 4'd2,
    OP_SAV = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_NEG = 4'd6,
    OP_JMP = 4'd7,
    OP_JEZ = 4'd8,
    OP_JNZ = 4'd9,
    OP_JGZ = 4'd10,
    OP_JLZ = 4'd11,
    OP_JRO = 4'd12
  } op_e;

  localparam logic [2:0] SRC_IN0 = 3'd0;
  localparam logic [2:0] SRC_IN1 = 3'd1;
  localparam logic [2:0] SRC_IN2 = 3'd2;
  localparam logic [2:0] SRC_IN3 = 3'd3;
  localparam logic [2:0] SRC_ACC = 3'd4;
  localparam logic [2:0] SRC_IMM = 3'd5;
  localparam logic [2:0] SRC_BAK = 3'd6;
  localparam logic [2:0] SRC_NIL = 3'd7;

  localparam logic [2:0] DST_OUT0 = 3'd0;
  localparam logic [2:0] DST_OUT1 = 3'd1;
  localparam logic [2:0] DST_OUT2 = 3'd2;
  localparam logic [2:0] DST_OUT3 = 3'd3;
  localparam logic [2:0] DST_ACC  = 3'd4;
  localparam logic [2:0] DST_BAK  = 3'd5;
  localparam logic [2:0] DST_NONE = 3'd7;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_NEG = 2'b10;

  localparam logic [1:0] SWPA_DATA = 2'b00;
  localparam logic [1:0] SWPA_ALU  = 2'b01;
  localparam logic [1:0] SWPA_ZERO = 2'b10;
  localparam logic [1:0] SWPA_BAK  = 2'b11;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_OUT_WAIT = 1'b1
  } state_e;

  // Field layout of one 18-bit instruction word, MSB first.
  typedef struct packed {
    logic [7:0] imm;
    logic [2:0] dst;
    logic [2:0] src;
    logic [3:0] op;
  } instr_t;

  // Instructions whose src operand is consumed, and so may block on a port.
  function automatic logic uses_src(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_JRO);
  endfunction

endpackage

// File: rtl/tis_node_ctrl_if.sv
// Neighbour-port handshake bundle between the node sequencer and its peers.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ack and out_valid/out_ack pairs per port.
interface tis_node_ctrl_if;
  logic [3:0] in_valid;
  logic [3:0] in_ack;
  logic [3:0] out_valid;
  logic [3:0] out_ack;

  modport master (
    input  in_valid,
    input  out_ack,
    output in_ack,
    output out_valid
  );

  modport slave (
    output in_valid,
    output out_ack,
    input  in_ack,
    input  out_valid
  );
endinterface

// File: rtl/tis_imem.sv
// Program RAM: DEPTH x IW words, synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none.
module tis_imem #(
  parameter int DEPTH = 16,
  parameter int IW    = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] mem [DEPTH];

  // Program load port; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/tis_node_ctrl.sv
// Node sequencer: program RAM, pc, decode to datapath bundle; optional TIS_DBG_EN adds dbg_halt/dbg_step.
// Latency: 1 cycle per non-port instruction; port write issues then waits in OUT_WAIT for out_ack.
// Backpressure: blocks (idle bundle, pc held) on missing in_valid or pending out_ack.
module tis_node_ctrl
  import tis_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [IW-1:0]         prog_data,
  input  logic [AW:0]           prog_len,
`ifdef TIS_DBG_EN
  input  logic                  dbg_halt,
  input  logic                  dbg_step,
`endif
  tis_node_ctrl_if.master       nb,
  input  logic [7:0]            ACCond,
  output logic                  SwpActiveReg,
  output logic [1:0]            SwpinA,
  output logic                  SwpinB,
  output logic                  jmpInstr,
  output logic [1:0]            ALUdesk,
  output logic [13:0]           datainstr,
  output logic [AW-1:0]         pc
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    wdst_q, wdst_d;
  logic [IW-1:0] rdata;
  instr_t        ins;
  logic          go;
  logic [2:0]    d_src, d_dst;
  logic [3:0]    in_ack_c, out_valid_c;

  tis_imem #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) u_imem (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (rdata)
  );

  assign ins = rdata;

`ifdef TIS_DBG_EN
  assign go = !dbg_halt || dbg_step;
`else
  assign go = 1'b1;
`endif

  // Next-pc candidates: sequential advance, absolute jump target, relative jump.
  logic [AW:0]        pc_inc;
  logic [AW-1:0]      pc_adv, jmp_tgt, jro_tgt;
  logic signed [9:0]  jro_off, jro_sum, len_m1;

  // Candidate program-counter values for advance, jumps and JRO clamping.
  always_comb begin
    pc_inc  = {1'b0, pc_q} + (AW+1)'(1);
    pc_adv  = (pc_inc >= prog_len) ? '0 : pc_inc[AW-1:0];
    jmp_tgt = ({1'b0, ins.imm[AW-1:0]} >= prog_len) ? '0 : ins.imm[AW-1:0];
    // Port data never reaches this block, so port-sourced offsets act as 0.
    case (ins.src)
      SRC_IMM: jro_off = {{2{ins.imm[7]}}, ins.imm};
      SRC_ACC: jro_off = {{2{ACCond[7]}}, ACCond};
      default: jro_off = '0;
    endcase
    jro_sum = $signed({{(10-AW){1'b0}}, pc_q}) + jro_off;
    len_m1  = $signed({{(9-AW){1'b0}}, prog_len}) - 10'sd1;
    if (jro_sum < 10'sd0)      jro_tgt = '0;
    else if (jro_sum > len_m1) jro_tgt = len_m1[AW-1:0];
    else                       jro_tgt = jro_sum[AW-1:0];
  end

  logic acc_zero, acc_neg, acc_pos, reads, port_rdy;
  assign acc_zero = (ACCond == 8'd0);
  assign acc_neg  = ACCond[7];
  assign acc_pos  = !acc_zero && !acc_neg;
  assign reads    = uses_src(ins.op) && !ins.src[2];
  assign port_rdy = nb.in_valid[ins.src[1:0]];

  // Decode, port handshakes and next-state; idle bundle unless an instruction issues.
  always_comb begin
    SwpActiveReg = 1'b0;
    SwpinA       = SWPA_ZERO;
    SwpinB       = 1'b0;
    jmpInstr     = 1'b1;
    ALUdesk      = ALU_ADD;
    d_src        = ins.src;
    d_dst        = DST_NONE;
    in_ack_c     = '0;
    state_d      = state_q;
    pc_d         = pc_q;
    wdst_d       = wdst_q;
    case (state_q)
      ST_RUN: begin
        if ((prog_len != '0) && go && (!reads || port_rdy)) begin
          if (reads) in_ack_c[ins.src[1:0]] = 1'b1;
          pc_d = pc_adv;
          case (ins.op)
            OP_MOV: begin
              jmpInstr = 1'b0;
              SwpinA   = SWPA_DATA;
              d_dst    = ins.dst;
              // Port write: datapath latches outX at this edge, then we wait for the ack.
              if (!ins.dst[2]) begin
                state_d = ST_OUT_WAIT;
                wdst_d  = ins.dst[1:0];
                pc_d    = pc_q;
              end
            end
            OP_SWP: begin
              jmpInstr     = 1'b0;
              SwpActiveReg = 1'b1;
              SwpinA       = SWPA_BAK;
              SwpinB       = 1'b1;
            end
            OP_SAV: begin
              jmpInstr     = 1'b0;
              SwpActiveReg = 1'b1;
              d_src        = SRC_ACC;
              SwpinA       = SWPA_DATA;
              SwpinB       = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              jmpInstr = 1'b0;
              d_dst    = DST_ACC;
              SwpinA   = SWPA_ALU;
              ALUdesk  = (ins.op == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            OP_NEG: begin
              jmpInstr = 1'b0;
              d_src    = SRC_ACC;
              d_dst    = DST_ACC;
              SwpinA   = SWPA_ALU;
              ALUdesk  = ALU_NEG;
            end
            OP_JMP: pc_d = jmp_tgt;
            OP_JEZ: if (acc_zero) pc_d = jmp_tgt;
            OP_JNZ: if (!acc_zero) pc_d = jmp_tgt;
            OP_JGZ: if (acc_pos) pc_d = jmp_tgt;
            OP_JLZ: if (acc_neg) pc_d = jmp_tgt;
            OP_JRO: pc_d = jro_tgt;
            default: ;
          endcase
        end
      end
      ST_OUT_WAIT: begin
        if (go && nb.out_ack[wdst_q]) begin
          state_d = ST_RUN;
          pc_d    = pc_adv;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pending write is visible on exactly one out_valid bit while in OUT_WAIT.
  always_comb begin
    out_valid_c = '0;
    if (state_q == ST_OUT_WAIT) out_valid_c[wdst_q] = 1'b1;
  end

  // Sequencer state; reset drops any pending port write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      wdst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wdst_q  <= wdst_d;
    end
  end

  assign nb.in_ack    = in_ack_c;
  assign nb.out_valid = out_valid_c;
  assign datainstr    = {d_src, d_dst, ins.imm};
  assign pc           = pc_q;

endmodule

// File: tb/tb_tis_node_ctrl.sv
// Directed bench for tis_node_ctrl: program load, decode, port blocking, jumps, reset.
// Latency: n/a.
// Backpressure: driven directly through the neighbour interface.
module tb_tis_node_ctrl;
  import tis_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [17:0] prog_data;
  logic [4:0]  prog_len;
  logic [7:0]  ACCond;
  logic        SwpActiveReg;
  logic [1:0]  SwpinA;
  logic        SwpinB;
  logic        jmpInstr;
  logic [1:0]  ALUdesk;
  logic [13:0] datainstr;
  logic [3:0]  pc;
  int          tests;
  int          fails;

  tis_node_ctrl_if nb ();

  tis_node_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_len     (prog_len),
`ifdef TIS_DBG_EN
    .dbg_halt     (1'b0),
    .dbg_step     (1'b0),
`endif
    .nb           (nb.master),
    .ACCond       (ACCond),
    .SwpActiveReg (SwpActiveReg),
    .SwpinA       (SwpinA),
    .SwpinB       (SwpinB),
    .jmpInstr     (jmpInstr),
    .ALUdesk      (ALUdesk),
    .datainstr    (datainstr),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] s,
                                     input logic [2:0] d, input logic [7:0] imm);
    return {imm, d, s, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [17:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_len = '0;
    ACCond = 8'd0;
    nb.in_valid = '0;
    nb.out_ack = '0;
    step();
    step();

    // Reset state
    chk("rst_pc", pc, 4'd0);
    chk("rst_out_valid", nb.out_valid, 4'b0000);
    chk("rst_in_ack", nb.in_ack, 4'b0000);

    // Program 1: MOV imm5->ACC; ADD imm3; JMP 0
    wr(4'd0, mk(OP_MOV, SRC_IMM, DST_ACC, 8'd5));
    wr(4'd1, mk(OP_ADD, SRC_IMM, DST_NONE, 8'd3));
    wr(4'd2, mk(OP_JMP, SRC_NIL, DST_NONE, 8'd0));
    rst_pulse();
    prog_len = 5'd3;
    #1;
    chk("p1_c0_pc", pc, 4'd0);
    chk("p1_c0_swpa", SwpinA, 2'b00);
    chk("p1_c0_jmp", jmpInstr, 1'b0);
    chk("p1_c0_data", datainstr, {3'd5, 3'd4, 8'd5});
    step();
    chk("p1_c1_pc", pc, 4'd1);
    chk("p1_c1_swpa", SwpinA, 2'b01);
    chk("p1_c1_alu", ALUdesk, 2'b00);
    chk("p1_c1_data", datainstr, {3'd5, 3'd4, 8'd3});
    step();
    chk("p1_c2_pc", pc, 4'd2);
    chk("p1_c2_jmp", jmpInstr, 1'b1);
    chk("p1_c2_dst", datainstr[10:8], 3'd7);
    step();
    chk("p1_c3_pc", pc, 4'd0);
    prog_len = 5'd0;
    step();
    chk("halt_pc", pc, 4'd0);
    chk("halt_swpa", SwpinA, 2'b10);
    chk("halt_jmp", jmpInstr, 1'b1);

    // Program 2: MOV in1->ACC blocks until in_valid[1]
    wr(4'd0, mk(OP_MOV, SRC_IN1, DST_ACC, 8'd0));
    wr(4'd1, mk(OP_NOP, SRC_NIL, DST_NONE, 8'd0));
    rst_pulse();
    prog_len = 5'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rd_wait_jmp", jmpInstr, 1'b1);
      chk("rd_wait_ack", nb.in_ack, 4'b0000);
      step();
    end
    chk("rd_wait_pc", pc, 4'd0);
    nb.in_valid = 4'b0010;
    #1;
    chk("rd_ack", nb.in_ack, 4'b0010);
    chk("rd_swpa", SwpinA, 2'b00);
    chk("rd_jmp", jmpInstr, 1'b0);
    step();
    nb.in_valid = 4'b0000;
    #1;
    chk("rd_pc", pc, 4'd1);
    chk("rd_ack_off", nb.in_ack, 4'b0000);

    // Program 3: MOV imm9->out2, ack withheld, wrong-port ack ignored
    prog_len = 5'd0;
    wr(4'd0, mk(OP_MOV, SRC_IMM, DST_OUT2, 8'd9));
    rst_pulse();
    prog_len = 5'd2;
    #1;
    chk("wr_issue_jmp", jmpInstr, 1'b0);
    chk("wr_issue_dst", datainstr[10:8], 3'd2);
    chk("wr_issue_ov", nb.out_valid, 4'b0000);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("wr_wait_ov", nb.out_valid, 4'b0100);
      chk("wr_wait_pc", pc, 4'd0);
      chk("wr_wait_jmp", jmpInstr, 1'b1);
      step();
    end
    nb.out_ack = 4'b0001;
    step();
    nb.out_ack = 4'b0000;
    chk("wr_wrongack_ov", nb.out_valid, 4'b0100);
    chk("wr_wrongack_pc", pc, 4'd0);
    nb.out_ack = 4'b0100;
    #1;
    chk("wr_ack_cycle_ov", nb.out_valid, 4'b0100);
    chk("wr_ack_cycle_inack", nb.in_ack, 4'b0000);
    step();
    nb.out_ack = 4'b0000;
    chk("wr_done_ov", nb.out_valid, 4'b0000);
    chk("wr_done_pc", pc, 4'd1);

    // Program 4: conditional jumps
    prog_len = 5'd0;
    wr(4'd0, mk(OP_JEZ, SRC_NIL, DST_NONE, 8'd2));
    wr(4'd1, mk(OP_JMP, SRC_NIL, DST_NONE, 8'd7));
    wr(4'd2, mk(OP_JGZ, SRC_NIL, DST_NONE, 8'd0));
    wr(4'd3, mk(OP_JLZ, SRC_NIL, DST_NONE, 8'd1));
    ACCond = 8'd0;
    rst_pulse();
    prog_len = 5'd4;
    #1;
    chk("j_pc0", pc, 4'd0);
    step();
    chk("j_jez_taken", pc, 4'd2);
    ACCond = 8'hFF;
    #1;
    chk("j_jmp_flag", jmpInstr, 1'b1);
    step();
    chk("j_jgz_not_taken", pc, 4'd3);
    step();
    chk("j_jlz_taken", pc, 4'd1);
    step();
    chk("j_jmp_oob", pc, 4'd0);

    // Program 5: JRO clamping
    prog_len = 5'd0;
    wr(4'd0, mk(OP_JMP, SRC_NIL, DST_NONE, 8'd2));
    wr(4'd1, mk(OP_JRO, SRC_IMM, DST_NONE, 8'hFB));
    wr(4'd2, mk(OP_JRO, SRC_IMM, DST_NONE, 8'd20));
    wr(4'd3, mk(OP_JMP, SRC_NIL, DST_NONE, 8'd1));
    rst_pulse();
    prog_len = 5'd4;
    step();
    chk("jro_pc2", pc, 4'd2);
    step();
    chk("jro_clamp_hi", pc, 4'd3);
    step();
    chk("jro_pc1", pc, 4'd1);
    step();
    chk("jro_clamp_lo", pc, 4'd0);

    // Program 6: reset during OUT_WAIT, then SWP/SAV
    prog_len = 5'd0;
    wr(4'd0, mk(OP_NOP, SRC_NIL, DST_NONE, 8'd0));
    wr(4'd1, mk(OP_MOV, SRC_IMM, DST_OUT2, 8'd9));
    rst_pulse();
    prog_len = 5'd2;
    step();
    step();
    chk("rw_ov", nb.out_valid, 4'b0100);
    chk("rw_pc", pc, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_async_ov", nb.out_valid, 4'b0000);
    chk("rw_async_pc", pc, 4'd0);
    prog_len = 5'd0;
    wr(4'd0, mk(OP_SWP, SRC_NIL, DST_NONE, 8'd0));
    wr(4'd1, mk(OP_SAV, SRC_NIL, DST_NONE, 8'd0));
    rst_n = 1'b1;
    prog_len = 5'd2;
    #1;
    chk("swp_act", SwpActiveReg, 1'b1);
    chk("swp_a", SwpinA, 2'b11);
    chk("swp_b", SwpinB, 1'b1);
    chk("swp_dst", datainstr[10:8], 3'd7);
    step();
    chk("sav_act", SwpActiveReg, 1'b1);
    chk("sav_a", SwpinA, 2'b00);
    chk("sav_b", SwpinB, 1'b1);
    chk("sav_src", datainstr[13:11], 3'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tis_node_ctrl.md
Name: tis_node_ctrl

Overview:
Per-node sequencer for a TIS-100-style execution node. Holds the program RAM and program counter, and decodes each instruction into the node datapath control bundle (SwpActiveReg, SwpinA, SwpinB, jmpInstr, ALUdesk, datainstr). Evaluates conditional jumps on ACCond fed back from the datapath. Enforces blocking valid/ack handshakes on the four neighbour ports, stalling the datapath while a port is not ready.

Parameters:
DEPTH, 16, program RAM words (power of 2, 2..256); AW = log2(DEPTH)
IW, 18, instruction width: op[0:3], src[4:6], dst[7:9], imm[10:17]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
prog_we  in  1  program RAM write strobe
prog_addr  in  AW  program RAM write address
prog_data  in  IW  program RAM write data
prog_len  in  AW+1  number of valid instructions; 0 = halted
in_valid  in  4  neighbour data valid on in0..in3
in_ack  out  4  one-cycle consume pulse per input port
out_valid  out  4  datapath outX holds unconsumed data
out_ack  in  4  neighbour has taken outX
ACCond  in  8  datapath ACC, signed
SwpActiveReg  out  1  force ACC/bak load
SwpinA  out  2  ACC source select: 00 data, 01 ALU, 10 zero, 11 bak
SwpinB  out  1  bak source: 1 = ACC, 0 = data
jmpInstr  out  1  suppress datapath port writes
ALUdesk  out  2  ALU op: 00 add, 01 sub, 10 neg (0-ACC)
datainstr  out  14  {src, dst, imm} to datapath
pc  out  AW  current program counter

Behaviour:
- Reset (async): pc=0, state RUN, out_valid=0, in_ack=0. RAM contents unaffected.
- RAM: synchronous write, asynchronous read at pc; a write to the pc address takes effect on the next read.
- src codes: 0-3 in0-3, 4 ACC, 5 imm, 6 bak, 7 NIL. dst codes: 0-3 out0-3, 4 ACC, 5 bak, 6/7 none.
- Idle bundle (stall, NOP, halted, OUT_WAIT): jmpInstr=1, dst=7, SwpActiveReg=0, SwpinA=10, SwpinB=0.
- Decode: MOV: SwpinA=00, pass src/dst/imm. ADD/SUB: dst forced 4, SwpinA=01, ALUdesk 00/01. NEG: src=4, dst=4, SwpinA=01, ALUdesk=10. SWP: SwpActiveReg=1, SwpinA=11, SwpinB=1, dst=7. SAV: SwpActiveReg=1, src=4, SwpinA=00, SwpinB=1, dst=7.
- Jumps (JMP, JEZ, JNZ, JGZ, JLZ): jmpInstr=1, dst=7. Taken: pc <= imm[AW-1:0], or 0 if that value is >= prog_len. Not taken: normal advance.
- JRO: pc <= clamp(pc + signed src value, 0, prog_len-1). A src of in0-3 follows the read rule.
- Advance: pc <= (pc == prog_len-1) ? 0 : pc+1. prog_len == 0: pc is held and the idle bundle is driven.
- Read rule (RUN, src 0-3): if in_valid[src]=0, drive the idle bundle and hold pc. Otherwise issue the instruction and pulse in_ack[src] in the same cycle.
- Write rule: the issue cycle with dst 0-3 (MOV only) latches datapath outX at the edge. The FSM then enters OUT_WAIT and sets out_valid[dst]=1 from the next cycle.
- OUT_WAIT: drive the idle bundle and hold pc. When out_ack[dst]=1: clear out_valid, advance pc, return to RUN. The earliest next issue is the cycle after the ack.
- Latency: non-port instruction 1 cycle; MOV inX to outY is minimum 2 cycles plus ack wait.
- out_ack on a port whose out_valid is low is ignored. in_ack is never asserted while in OUT_WAIT.
- Reset mid-OUT_WAIT drops the pending write: out_valid=0, pc=0.

Optional Feature:
TIS_DBG_EN
- With macro: adds input dbg_halt and input dbg_step. While dbg_halt=1, the idle bundle is driven and pc is held. A dbg_step pulse issues exactly one instruction (or one OUT_WAIT resolution attempt). The pc port reflects the live pc.
- Without macro: these ports are absent and the pc port is still driven.

Decomposition:
- Package tis_pkg: opcode enum (NOP, MOV, SWP, SAV, ADD, SUB, NEG, JMP, JEZ, JNZ, JGZ, JLZ, JRO), SRC_*/DST_* codes, ALU_* codes, SWPA_* codes, FSM state enum {RUN, OUT_WAIT}.
- One sub-module, tis_imem: DEPTH x IW RAM, sync write, async read.

Test Plan:
- Program [MOV imm 5 -> ACC; ADD imm 3; JMP 0], prog_len=3 -> bundle SwpinA 00/01/jmpInstr=1 on cycles 0/1/2; pc sequence 0,1,2,0.
- MOV in1 -> ACC with in_valid[1]=0 for 4 cycles, then 1 -> idle bundle for 4 cycles, in_ack[1] single pulse on the 5th cycle, pc advances once.
- MOV imm 9 -> out2, out_ack[2] held low 3 cycles -> out_valid[2]=1 from cycle 1 until the cycle out_ack[2]=1, pc held, then pc+1.
- JEZ 2 with ACCond=0 -> pc=2; with ACCond=8'hFF: JLZ taken, JGZ not taken.
- JRO imm -5 at pc=1 -> pc=0; JRO imm 20 with prog_len=4 -> pc=3.
- Assert rst_n=0 during OUT_WAIT -> out_valid=0 and pc=0 immediately (async); SWP after release -> SwpActiveReg=1, SwpinA=11, SwpinB=1.
